// File: rtl/tff_toggle_gen_if.sv
// Button-side and flip-flop-side signals of the toggle generator.
// The master drives the raw button and repeat enable; the slave returns the strobe and status.
interface tff_toggle_gen_if;
  logic       btn;
  logic       rep_en;
  logic       t;
  logic       btn_db;
  logic [7:0] press_cnt;

  modport master (
    output btn,
    output rep_en,
    input  t,
    input  btn_db,
    input  press_cnt
  );

  modport slave (
    input  btn,
    input  rep_en,
    output t,
    output btn_db,
    output press_cnt
  );
endinterface

// File: rtl/tff_toggle_gen.sv
// Push-button to T flip-flop toggle strobe: 2-flop synchronizer, debounce FSM,
// one-cycle t pulse per confirmed press plus optional auto-repeat while held.
module tff_toggle_gen #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_CYCLES = 10,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              clr,
  tff_toggle_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYCLES);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             t_q, t_d;
  logic             btn_db_q, btn_db_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

  logic             enter_held, rep_fire, release_done;
  logic [CNT_W-1:0] deb_inc, rep_inc;

  assign deb_inc = deb_cnt_q + ONE;
  assign rep_inc = rep_cnt_q + ONE;

  always_ff @(posedge clk) begin
    if (!clr) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      t_q         <= 1'b0;
      btn_db_q    <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      s1_q        <= bus.btn;
      s2_q        <= s1_q;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      t_q         <= t_d;
      btn_db_q    <= btn_db_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  // Transition events are flagged here so the outputs can register on the same edge as the state change.
  always_comb begin
    state_d      = state_q;
    deb_cnt_d    = deb_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    enter_held   = 1'b0;
    rep_fire     = 1'b0;
    release_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        deb_cnt_d = '0;
        rep_cnt_d = '0;
        if (s2_q) begin
          if (DEB_CYCLES == 1) begin
            state_d    = HELD;
            enter_held = 1'b1;
          end else begin
            state_d   = PRESS_WAIT;
            deb_cnt_d = ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_inc == DEB_MAX) begin
          state_d    = HELD;
          deb_cnt_d  = '0;
          rep_cnt_d  = '0;
          enter_held = 1'b1;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      HELD: begin
        if (!s2_q) begin
          rep_cnt_d = '0;
          if (DEB_CYCLES == 1) begin
            state_d      = IDLE;
            release_done = 1'b1;
          end else begin
            state_d   = RELEASE_WAIT;
            deb_cnt_d = ONE;
          end
        end else if (bus.rep_en) begin
          if (rep_inc == REP_MAX) begin
            rep_cnt_d = '0;
            rep_fire  = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end else begin
          rep_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d   = HELD;
          deb_cnt_d = '0;
          rep_cnt_d = '0;
        end else if (deb_inc == DEB_MAX) begin
          state_d      = IDLE;
          deb_cnt_d    = '0;
          release_done = 1'b1;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t_d         = enter_held | rep_fire;
    btn_db_d    = btn_db_q;
    press_cnt_d = press_cnt_q + 8'(enter_held);
    if (enter_held)   btn_db_d = 1'b1;
    if (release_done) btn_db_d = 1'b0;
  end

  assign bus.t         = t_q;
  assign bus.btn_db    = btn_db_q;
  assign bus.press_cnt = press_cnt_q;

endmodule

// File: tb/tb_tff_toggle_gen.sv
// Directed bench for tff_toggle_gen with default parameters (DEB_CYCLES=4, REPEAT_CYCLES=10).
module tb_tff_toggle_gen;
  logic clk = 1'b0;
  logic clr;

  tff_toggle_gen_if bus ();

  tff_toggle_gen #(
    .DEB_CYCLES(4),
    .REPEAT_CYCLES(10),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Window statistics gathered by ticks(); edge_idx numbers edges from the last window start.
  int pulses;
  int first_pe;
  int last_pe;
  int edge_idx;
  int db_low_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic window();
    pulses      = 0;
    first_pe    = -1;
    last_pe     = -1;
    edge_idx    = -1;
    db_low_seen = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_idx++;
      if (bus.t === 1'b1) begin
        pulses++;
        if (first_pe < 0) first_pe = edge_idx;
        last_pe = edge_idx;
      end
      if (bus.btn_db !== 1'b1) db_low_seen++;
    end
  endtask

  task automatic do_reset();
    clr = 1'b0;
    ticks(2);
    clr = 1'b1;
  endtask

  initial begin
    clr        = 1'b0;
    bus.btn    = 1'b1;
    bus.rep_en = 1'b0;

    // 1: reset with button held, then release of reset
    window();
    ticks(2);
    chk("rst_t", 32'(bus.t), 32'd0);
    chk("rst_db", 32'(bus.btn_db), 32'd0);
    chk("rst_cnt", 32'(bus.press_cnt), 32'd0);
    clr = 1'b1;
    window();
    ticks(5);
    chk("rst_rel_early_pulses", 32'(pulses), 32'd0);
    chk("rst_rel_early_db", 32'(bus.btn_db), 32'd0);
    ticks(1);
    chk("rst_rel_t", 32'(bus.t), 32'd1);
    chk("rst_rel_cnt", 32'(bus.press_cnt), 32'd1);
    ticks(1);
    chk("rst_rel_t_one_cycle", 32'(bus.t), 32'd0);

    // 2: clean press, no repeat
    bus.btn = 1'b0;
    do_reset();
    ticks(6);
    window();
    bus.btn = 1'b1;
    ticks(5);
    chk("clean_early_db", 32'(bus.btn_db), 32'd0);
    ticks(1);
    chk("clean_t_edge5", 32'(bus.t), 32'd1);
    chk("clean_db_edge5", 32'(bus.btn_db), 32'd1);
    ticks(24);
    chk("clean_single_pulse", 32'(pulses), 32'd1);
    bus.btn = 1'b0;
    ticks(5);
    chk("clean_db_before_rel", 32'(bus.btn_db), 32'd1);
    ticks(1);
    chk("clean_db_edge35", 32'(bus.btn_db), 32'd0);
    chk("clean_cnt", 32'(bus.press_cnt), 32'd1);
    chk("clean_total_pulses", 32'(pulses), 32'd1);

    // 3: bounce 2 high, 1 low, 1 high, 1 low, then stable
    do_reset();
    ticks(6);
    window();
    bus.btn = 1'b1; ticks(2);
    bus.btn = 1'b0; ticks(1);
    bus.btn = 1'b1; ticks(1);
    bus.btn = 1'b0; ticks(1);
    bus.btn = 1'b1;
    ticks(5);
    chk("bounce_no_pulse", 32'(pulses), 32'd0);
    chk("bounce_db_low", 32'(bus.btn_db), 32'd0);
    ticks(1);
    chk("bounce_t", 32'(bus.t), 32'd1);
    ticks(5);
    chk("bounce_pulses", 32'(pulses), 32'd1);
    chk("bounce_cnt", 32'(bus.press_cnt), 32'd1);

    // 4: auto-repeat
    bus.btn = 1'b0;
    do_reset();
    ticks(6);
    bus.rep_en = 1'b1;
    window();
    bus.btn = 1'b1;
    ticks(40);
    chk("rep_pulses", 32'(pulses), 32'd4);
    chk("rep_first", 32'(first_pe), 32'd5);
    chk("rep_last", 32'(last_pe), 32'd35);
    chk("rep_cnt", 32'(bus.press_cnt), 32'd1);

    // 5: release glitch while held, repeat restarts on re-entry
    window();
    bus.btn = 1'b0;
    ticks(2);
    bus.btn = 1'b1;
    ticks(12);
    chk("glitch_no_pulse", 32'(pulses), 32'd0);
    chk("glitch_db_held", 32'(db_low_seen), 32'd0);
    ticks(1);
    chk("glitch_repeat_t", 32'(bus.t), 32'd1);
    chk("glitch_cnt", 32'(bus.press_cnt), 32'd1);

    // 6: 256 presses wrap the count, then reset mid-hold
    bus.rep_en = 1'b0;
    bus.btn    = 1'b0;
    do_reset();
    ticks(6);
    window();
    for (int i = 0; i < 256; i++) begin
      bus.btn = 1'b1; ticks(7);
      bus.btn = 1'b0; ticks(7);
    end
    chk("wrap_pulses", 32'(pulses), 32'd256);
    chk("wrap_cnt", 32'(bus.press_cnt), 32'd0);
    bus.btn = 1'b1;
    ticks(8);
    chk("wrap_next_cnt", 32'(bus.press_cnt), 32'd1);
    chk("held_db", 32'(bus.btn_db), 32'd1);
    clr = 1'b0;
    ticks(1);
    chk("midhold_rst_db", 32'(bus.btn_db), 32'd0);
    chk("midhold_rst_cnt", 32'(bus.press_cnt), 32'd0);
    clr = 1'b1;
    window();
    ticks(5);
    chk("midhold_early_db", 32'(bus.btn_db), 32'd0);
    ticks(1);
    chk("midhold_t", 32'(bus.t), 32'd1);
    chk("midhold_cnt", 32'(bus.press_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tff_toggle_gen.md
Name: tff_toggle_gen

Overview:
- Upstream stage for the T flip-flop (tffcase). Turns a raw, bouncing push-button into the flip-flop's `t` toggle strobe.
- Pipeline: a 2-flop synchronizer, then a debounce FSM, then a single-cycle `t` pulse on each confirmed press.
- Optional auto-repeat pulses while the button is held.
- Also provides the debounced level and a wrapping count of confirmed presses.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized samples needed to confirm a level change; legal range is 1 or more.
- REPEAT_CYCLES, 10, clock edges between auto-repeat pulses while held; legal range is 2 or more.
- CNT_W, 16, width of the internal debounce/repeat counters; must hold max(DEB_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- clr  input  1  reset, synchronous, active-low.
- btn  input  1  raw asynchronous push-button, active-high.
- rep_en  input  1  auto-repeat enable.
- t  output  1  toggle strobe to the T flip-flop; one-cycle pulses.
- btn_db  output  1  debounced button level.
- press_cnt  output  8  count of confirmed presses.

Behaviour:
- Reset (clr low at a rising edge):
  - Synchronizer flops s1 and s2 go to 0; the FSM goes to IDLE; all counters clear.
  - t=0, btn_db=0, press_cnt=0.
  - Reset takes priority over all other events, including a reset mid-press or mid-hold.
- Synchronizer: s1<=btn, s2<=s1. The FSM acts only on s2, never on btn directly.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE, s2=1: if DEB_CYCLES=1, go to HELD; otherwise go to PRESS_WAIT with deb_cnt=1.
  - PRESS_WAIT, s2=0: go to IDLE, deb_cnt=0. No t pulse.
  - PRESS_WAIT, s2=1: deb_cnt++. When the count reaches DEB_CYCLES, go to HELD.
  - Entry into HELD from PRESS_WAIT or IDLE (registered outputs):
    - t=1 for exactly one cycle.
    - btn_db=1.
    - press_cnt++.
    - rep_cnt=0.
  - HELD, s2=1, rep_en=1: rep_cnt++. When rep_cnt reaches REPEAT_CYCLES, pulse t=1 for one cycle and set rep_cnt=0.
  - HELD, s2=1, rep_en=0: rep_cnt held at 0; no pulses. Re-asserting rep_en starts a full REPEAT_CYCLES interval.
  - HELD, s2=0: go to RELEASE_WAIT with deb_cnt=1 (or straight to IDLE if DEB_CYCLES=1).
  - RELEASE_WAIT, s2=1: go back to HELD with rep_cnt=0. No t pulse, no press_cnt increment.
  - RELEASE_WAIT, s2=0: deb_cnt++. When the count reaches DEB_CYCLES, go to IDLE with btn_db=0.
- Outputs:
  - t is registered and low at all other times.
  - t is never high on two consecutive cycles (REPEAT_CYCLES≥2 guarantees this).
  - press_cnt wraps 255→0. Repeat pulses do not increment it.
- Latency: with btn rising just before edge 0 and held stable:
  - s2 is first sampled high at edge 2.
  - t and btn_db go high after edge DEB_CYCLES+1, i.e. 3 edges of synchronizer and decision delay plus DEB_CYCLES-1 counting edges.
- Release latency is symmetric: btn_db falls after edge DEB_CYCLES+1 relative to btn falling before edge 0.
- Bounce: any s2 level change inside PRESS_WAIT or RELEASE_WAIT restarts the confirmation from the prior stable state, as per the transitions above.

Test Plan (defaults DEB_CYCLES=4, REPEAT_CYCLES=10):
1. Reset: clr=0 for 2 edges with btn=1 → t=0, btn_db=0, press_cnt=0. Release clr with btn=1 stable → t pulses once after edge 5 of the release, then press_cnt=1.
2. Clean press, rep_en=0: btn high before edge 0 for 30 edges, then low → exactly one t pulse (after edge 5) and btn_db=1 from edge 5. After the fall before edge 30, btn_db=0 after edge 35; press_cnt=1.
3. Bounce: btn high 2 edges, low 1, high 1, low 1, then stable high → no t pulse during the bounce; exactly one pulse 5 edges after the final rising; press_cnt=1.
4. Auto-repeat: rep_en=1, btn high from before edge 0 for 40 edges → t pulses after edges 5, 15, 25 and 35 (4 pulses); press_cnt=1.
5. Release glitch: while HELD, btn low for 2 edges then high → btn_db stays 1, no t pulse, press_cnt unchanged. With rep_en=1, the next repeat comes 10 edges after re-entering HELD.
6. Wrap and mid-hold reset: 256 confirmed presses → press_cnt=0. clr=0 during HELD → btn_db=0 next cycle; after clr release with btn still high, a new press is confirmed with press_cnt=1.
